// File: rtl/draw_seq_pkg.sv
// draw_seq_pkg: state encoding and small helpers shared by the draw sequencer.
// Feature macro used by the sequencer: DRAW_SEQ_TIMEOUT_EN (plot watchdog).
package draw_seq_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    DRAW_START = 4'd1,
    WAIT_BG    = 4'd2,
    DRAW_BG    = 4'd3,
    SELECT     = 4'd4,
    WAIT_OVL   = 4'd5,
    DRAW_OVL   = 4'd6,
    WAIT_TICK  = 4'd7
  } state_t;

  // Width of an index into an n-wide vector; never zero so a 1-channel build stays legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// prio_pick: lowest-set-bit search. Bit 0 wins; valid flags any request at all.
module prio_pick
  import draw_seq_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: steps the plotter through start screen, background and
// status overlays once per frame, flagging frames whose tick arrives mid-draw.
// Optional feature macro: DRAW_SEQ_TIMEOUT_EN adds a plot watchdog that forces
// completion after TIMEOUT_CYCLES cycles in a draw state and sets plot_timeout.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int NUM_STATUS     = 6,
  parameter int SEQ_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                go,
  input  logic                                go_start,
  input  logic                                plot_done,
  input  logic                                frame_tick,
  input  logic [NUM_STATUS-1:0]               status_en,
  output logic                                draw_scrn_start,
  output logic                                draw_scrn_game_bg,
  output logic [NUM_STATUS-1:0]               draw_ovl,
  output logic [idx_width(NUM_STATUS)-1:0]    ovl_idx,
  output logic                                frame_overrun,
  output logic                                plot_timeout,
  output logic [3:0]                          current_state
);

  localparam int IDX_W = idx_width(NUM_STATUS);

  if (NUM_STATUS < 1 || NUM_STATUS > 16) begin : g_bad_num_status
    $error("draw_sequencer: NUM_STATUS must be 1..16");
  end
  if (SEQ_MODE != 0 && SEQ_MODE != 1) begin : g_bad_seq_mode
    $error("draw_sequencer: SEQ_MODE must be 0 or 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("draw_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  state_t                state;
  state_t                state_nxt;
  logic [NUM_STATUS-1:0] pending;
  logic [NUM_STATUS-1:0] snap_mask;
  logic [NUM_STATUS-1:0] ovl_mask;
  logic                  tick_pending;
  logic [IDX_W-1:0]      pend_idx;
  logic                  pend_valid;
  logic                  done_eff;
  logic                  overrun_state;

  // The overlay picked in SELECT is always the lowest outstanding request.
  prio_pick #(.WIDTH(NUM_STATUS), .IDX_W(IDX_W)) u_pick_pending (
    .req   (pending),
    .idx   (pend_idx),
    .valid (pend_valid)
  );

  if (SEQ_MODE == 0) begin : g_snap_single
    logic [IDX_W-1:0] snap_idx;
    logic             snap_valid;

    // Single-overlay mode keeps only the highest-priority request of the snapshot.
    prio_pick #(.WIDTH(NUM_STATUS), .IDX_W(IDX_W)) u_pick_snap (
      .req   (status_en),
      .idx   (snap_idx),
      .valid (snap_valid)
    );
    assign snap_mask = snap_valid ? (NUM_STATUS'(1) << snap_idx) : '0;
  end else begin : g_snap_all
    assign snap_mask = status_en;
  end

  assign ovl_mask      = NUM_STATUS'(1) << ovl_idx;
  assign overrun_state = !(state inside {IDLE, DRAW_START, WAIT_TICK});

`ifdef DRAW_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] dwell_cnt;
  logic             in_draw;
  logic             timeout_hit;

  assign in_draw     = state inside {DRAW_START, DRAW_BG, DRAW_OVL};
  assign timeout_hit = in_draw && (dwell_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done_eff    = plot_done | timeout_hit;

  // Watchdog: count cycles spent in one draw state, restart on any state change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dwell_cnt    <= '0;
      plot_timeout <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        dwell_cnt <= '0;
      end else if (in_draw && !timeout_hit) begin
        dwell_cnt <= dwell_cnt + CNT_W'(1);
      end
      if (timeout_hit) plot_timeout <= 1'b1;
    end
  end
`else
  assign done_eff     = plot_done;
  assign plot_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; plot_done only matters in the draw states that wait on it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (go)       state_nxt = DRAW_START;
      DRAW_START: if (go_start) state_nxt = WAIT_BG;
      WAIT_BG:    if (go)       state_nxt = DRAW_BG;
      DRAW_BG:    if (done_eff) state_nxt = SELECT;
      SELECT:     state_nxt = pend_valid ? WAIT_OVL : WAIT_TICK;
      WAIT_OVL:   if (go)       state_nxt = DRAW_OVL;
      DRAW_OVL:   if (done_eff) state_nxt = SELECT;
      WAIT_TICK:  if (frame_tick || tick_pending) state_nxt = DRAW_BG;
      default:    state_nxt = IDLE;
    endcase
  end

  // Moore plot enables decoded from the current state only.
  always_comb begin
    draw_scrn_start   = (state == DRAW_START);
    draw_scrn_game_bg = (state == DRAW_BG);
    draw_ovl          = (state == DRAW_OVL) ? ovl_mask : '0;
  end

  assign current_state = state;

  // Overlay bookkeeping, missed-tick memory and the overrun pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending       <= '0;
      tick_pending  <= 1'b0;
      ovl_idx       <= '0;
      frame_overrun <= 1'b0;
    end else begin
      frame_overrun <= frame_tick & overrun_state;

      if (state == DRAW_BG && done_eff) begin
        pending <= snap_mask;
      end else if (state == DRAW_OVL && done_eff) begin
        pending <= pending & ~ovl_mask;
      end

      if (state == SELECT && pend_valid) ovl_idx <= pend_idx;

      if (frame_tick && overrun_state) begin
        tick_pending <= 1'b1;
      end else if (state == WAIT_TICK && (frame_tick || tick_pending)) begin
        tick_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: two sequencers (single- and all-overlay mode) driven by
// directed frames and random traffic, checked every cycle against a frame model.
module tb_draw_sequencer;

  localparam int N  = 6;
  localparam int TO = 16;

  localparam int S_IDLE = 0, S_DRAW_START = 1, S_WAIT_BG = 2, S_DRAW_BG = 3;
  localparam int S_SELECT = 4, S_WAIT_OVL = 5, S_DRAW_OVL = 6, S_WAIT_TICK = 7;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic go_i [2];
  logic go_start_i [2];
  logic plot_done_i [2];
  logic frame_tick_i [2];
  logic [N-1:0] status_en_i [2];

  logic d0_start, d0_bg, d0_ovr, d0_to;
  logic [N-1:0] d0_ovl;
  logic [2:0] d0_idx;
  logic [3:0] d0_state;
  logic d1_start, d1_bg, d1_ovr, d1_to;
  logic [N-1:0] d1_ovl;
  logic [2:0] d1_idx;
  logic [3:0] d1_state;

  int tests_run = 0;
  int tests_failed = 0;

  // Frame model: phase, outstanding overlays, selected overlay, remembered tick.
  int ph [2];
  logic [N-1:0] pend [2];
  int cur [2];
  bit tp [2];
  bit ovr [2];
  bit tflag [2];
  int dwell [2];

  draw_sequencer #(.NUM_STATUS(N), .SEQ_MODE(0), .TIMEOUT_CYCLES(TO)) u_dut0 (
    .clk(clk), .resetn(resetn), .go(go_i[0]), .go_start(go_start_i[0]),
    .plot_done(plot_done_i[0]), .frame_tick(frame_tick_i[0]), .status_en(status_en_i[0]),
    .draw_scrn_start(d0_start), .draw_scrn_game_bg(d0_bg), .draw_ovl(d0_ovl),
    .ovl_idx(d0_idx), .frame_overrun(d0_ovr), .plot_timeout(d0_to), .current_state(d0_state)
  );

  draw_sequencer #(.NUM_STATUS(N), .SEQ_MODE(1), .TIMEOUT_CYCLES(TO)) u_dut1 (
    .clk(clk), .resetn(resetn), .go(go_i[1]), .go_start(go_start_i[1]),
    .plot_done(plot_done_i[1]), .frame_tick(frame_tick_i[1]), .status_en(status_en_i[1]),
    .draw_scrn_start(d1_start), .draw_scrn_game_bg(d1_bg), .draw_ovl(d1_ovl),
    .ovl_idx(d1_idx), .frame_overrun(d1_ovr), .plot_timeout(d1_to), .current_state(d1_state)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input int m, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL dut%0d %s: got 0x%0h, expected 0x%0h at %0t", m, name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ph[m] = S_IDLE; pend[m] = '0; cur[m] = 0; tp[m] = 0;
      ovr[m] = 0; tflag[m] = 0; dwell[m] = 0;
    end
  endtask

  // One clock edge of the frame rules for sequencer m (m doubles as its mode).
  task automatic model_step(input int m, input logic g, input logic gs, input logic pd,
                            input logic ft, input logic [N-1:0] se);
    int old;
    bit in_draw;
    bit forced;
    bit done;
    logic [N-1:0] one;
    old = ph[m];
    in_draw = (old == S_DRAW_START || old == S_DRAW_BG || old == S_DRAW_OVL);
    forced = 0;
    one = 1;
`ifdef DRAW_SEQ_TIMEOUT_EN
    forced = in_draw && (dwell[m] == TO - 1);
    if (forced) tflag[m] = 1;
`endif
    done = pd || forced;
    ovr[m] = ft && !(old == S_IDLE || old == S_DRAW_START || old == S_WAIT_TICK);
    case (old)
      S_IDLE:       if (g) ph[m] = S_DRAW_START;
      S_DRAW_START: if (gs) ph[m] = S_WAIT_BG;
      S_WAIT_BG:    if (g) ph[m] = S_DRAW_BG;
      S_DRAW_BG: if (done) begin
        pend[m] = (m == 0 && se != 0) ? (one << lowest(se)) : se;
        ph[m] = S_SELECT;
      end
      S_SELECT: if (pend[m] != 0) begin
        cur[m] = lowest(pend[m]);
        ph[m] = S_WAIT_OVL;
      end else begin
        ph[m] = S_WAIT_TICK;
      end
      S_WAIT_OVL: if (g) ph[m] = S_DRAW_OVL;
      S_DRAW_OVL: if (done) begin
        pend[m][cur[m]] = 1'b0;
        ph[m] = S_SELECT;
      end
      S_WAIT_TICK: if (ft || tp[m]) begin
        tp[m] = 0;
        ph[m] = S_DRAW_BG;
      end
      default: ph[m] = S_IDLE;
    endcase
    if (ovr[m]) tp[m] = 1;
`ifdef DRAW_SEQ_TIMEOUT_EN
    if (ph[m] != old) dwell[m] = 0;
    else if (in_draw && !forced) dwell[m]++;
`endif
  endtask

  // Advance the model on every edge, and reset it with the DUTs.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_reset();
    end else begin
      model_step(0, go_i[0], go_start_i[0], plot_done_i[0], frame_tick_i[0], status_en_i[0]);
      model_step(1, go_i[1], go_start_i[1], plot_done_i[1], frame_tick_i[1], status_en_i[1]);
    end
  end

  task automatic compare_dut(input int m, input logic st, input logic bg, input logic [N-1:0] ovl,
                             input logic [2:0] idx, input logic ov, input logic to,
                             input logic [3:0] cs);
    logic [N-1:0] exp_ovl;
    exp_ovl = '0;
    if (ph[m] == S_DRAW_OVL) exp_ovl[cur[m]] = 1'b1;
    checkOutput("current_state", m, 32'(cs), 32'(ph[m]));
    checkOutput("draw_scrn_start", m, 32'(st), 32'(ph[m] == S_DRAW_START));
    checkOutput("draw_scrn_game_bg", m, 32'(bg), 32'(ph[m] == S_DRAW_BG));
    checkOutput("draw_ovl", m, 32'(ovl), 32'(exp_ovl));
    checkOutput("ovl_idx", m, 32'(idx), 32'(cur[m]));
    checkOutput("frame_overrun", m, 32'(ov), 32'(ovr[m]));
    checkOutput("plot_timeout", m, 32'(to), 32'(tflag[m]));
  endtask

  // Compare both DUTs against the model mid-cycle whenever reset is released.
  always @(negedge clk) begin
    if (resetn) begin
      compare_dut(0, d0_start, d0_bg, d0_ovl, d0_idx, d0_ovr, d0_to, d0_state);
      compare_dut(1, d1_start, d1_bg, d1_ovl, d1_idx, d1_ovr, d1_to, d1_state);
    end
  end

  // Drive one DUT for one edge (the other idles); returns mid-cycle after the edge.
  task automatic applyStimulus(input int m, input logic g, input logic gs, input logic pd,
                               input logic ft, input logic [N-1:0] se);
    for (int k = 0; k < 2; k++) begin
      go_i[k] = 0; go_start_i[k] = 0; plot_done_i[k] = 0; frame_tick_i[k] = 0;
      status_en_i[k] = '0;
    end
    go_i[m] = g; go_start_i[m] = gs; plot_done_i[m] = pd; frame_tick_i[m] = ft;
    status_en_i[m] = se;
    @(negedge clk);
    #1;
  endtask

  task automatic applyRandom();
    for (int k = 0; k < 2; k++) begin
      go_i[k]         = ($urandom_range(0, 99) < 30);
      go_start_i[k]   = ($urandom_range(0, 99) < 30);
      plot_done_i[k]  = ($urandom_range(0, 99) < 25);
      frame_tick_i[k] = ($urandom_range(0, 99) < 10);
      status_en_i[k]  = N'($urandom);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      go_i[k] = 0; go_start_i[k] = 0; plot_done_i[k] = 0; frame_tick_i[k] = 0;
      status_en_i[k] = '0;
    end
    #12;
    checkOutput("reset_state", 0, 32'(d0_state), 0);
    checkOutput("reset_state", 1, 32'(d1_state), 0);
    checkOutput("reset_draw_ovl", 0, 32'(d0_ovl), 0);
    checkOutput("reset_ovl_idx", 1, 32'(d1_idx), 0);
    checkOutput("reset_timeout", 0, 32'(d0_to), 0);
    resetn = 1'b1;

    // Mode 1: overlays 0 then 5, snapshot ignores status_en dropping to 0.
    applyStimulus(1, 1, 0, 0, 0, '0);
    checkOutput("m1_draw_start", 1, 32'(d1_start), 1);
    applyStimulus(1, 0, 1, 0, 0, '0);
    applyStimulus(1, 1, 0, 0, 0, '0);
    checkOutput("m1_bg", 1, 32'(d1_bg), 1);
    applyStimulus(1, 0, 0, 1, 0, 6'b100001);
    checkOutput("m1_select", 1, 32'(d1_state), S_SELECT);
    applyStimulus(1, 0, 0, 0, 0, '0);
    checkOutput("m1_idx_first", 1, 32'(d1_idx), 0);
    applyStimulus(1, 1, 0, 0, 0, '0);
    checkOutput("m1_ovl_first", 1, 32'(d1_ovl), 32'(6'b000001));
    applyStimulus(1, 0, 0, 1, 0, '0);
    applyStimulus(1, 0, 0, 0, 0, '0);
    checkOutput("m1_idx_second", 1, 32'(d1_idx), 5);
    applyStimulus(1, 1, 0, 0, 0, '0);
    checkOutput("m1_ovl_second", 1, 32'(d1_ovl), 32'(6'b100000));
    applyStimulus(1, 0, 0, 1, 0, '0);
    applyStimulus(1, 0, 0, 0, 0, '0);
    checkOutput("m1_wait_tick", 1, 32'(d1_state), S_WAIT_TICK);

    // Tick during an overlay draw: overrun pulse, then WAIT_TICK exits on its own.
    applyStimulus(1, 0, 0, 0, 1, '0);
    applyStimulus(1, 0, 0, 1, 0, 6'b000001);
    applyStimulus(1, 0, 0, 0, 0, '0);
    applyStimulus(1, 1, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, 1, '0);
    checkOutput("ovr_pulse", 1, 32'(d1_ovr), 1);
    applyStimulus(1, 0, 0, 0, 0, '0);
    checkOutput("ovr_pulse_end", 1, 32'(d1_ovr), 0);
    applyStimulus(1, 0, 0, 1, 0, '0);
    applyStimulus(1, 0, 0, 0, 0, '0);
    checkOutput("ovr_wait_tick", 1, 32'(d1_state), S_WAIT_TICK);
    applyStimulus(1, 0, 0, 0, 0, '0);
    checkOutput("ovr_auto_bg", 1, 32'(d1_state), S_DRAW_BG);
    applyStimulus(1, 0, 0, 1, 0, '0);
    applyStimulus(1, 0, 0, 0, 0, '0);

    // Mode 0: only the highest-priority request of 010100 is drawn.
    applyStimulus(0, 1, 0, 0, 0, '0);
    applyStimulus(0, 0, 1, 0, 0, '0);
    applyStimulus(0, 1, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, 6'b010100);
    applyStimulus(0, 0, 0, 0, 0, '0);
    checkOutput("m0_idx", 0, 32'(d0_idx), 2);
    applyStimulus(0, 1, 0, 0, 0, '0);
    checkOutput("m0_ovl", 0, 32'(d0_ovl), 32'(6'b000100));
    applyStimulus(0, 0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);
    checkOutput("m0_wait_tick", 0, 32'(d0_state), S_WAIT_TICK);

    // No requests at background done: straight through SELECT to WAIT_TICK.
    applyStimulus(0, 0, 0, 0, 1, '0);
    checkOutput("empty_bg", 0, 32'(d0_state), S_DRAW_BG);
    applyStimulus(0, 0, 0, 1, 0, '0);
    checkOutput("empty_select", 0, 32'(d0_state), S_SELECT);
    applyStimulus(0, 0, 0, 0, 0, '0);
    checkOutput("empty_wait_tick", 0, 32'(d0_state), S_WAIT_TICK);

    // Asynchronous reset mid-draw drops the enable before the next edge.
    applyStimulus(0, 0, 0, 0, 1, '0);
    checkOutput("pre_reset_bg", 0, 32'(d0_bg), 1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_reset_bg", 0, 32'(d0_bg), 0);
    checkOutput("async_reset_state", 0, 32'(d0_state), S_IDLE);
    @(negedge clk);
    #1;
    resetn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, '0);
    checkOutput("post_reset_idle", 0, 32'(d0_state), S_IDLE);

    // Background plot that never reports done.
    applyStimulus(0, 1, 0, 0, 0, '0);
    applyStimulus(0, 0, 1, 0, 0, '0);
    applyStimulus(0, 1, 0, 0, 0, '0);
    repeat (TO - 1) applyStimulus(0, 0, 0, 0, 0, '0);
    checkOutput("stall_still_bg", 0, 32'(d0_state), S_DRAW_BG);
    applyStimulus(0, 0, 0, 0, 0, '0);
`ifdef DRAW_SEQ_TIMEOUT_EN
    checkOutput("timeout_select", 0, 32'(d0_state), S_SELECT);
    checkOutput("timeout_flag", 0, 32'(d0_to), 1);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, '0);
    checkOutput("timeout_sticky", 0, 32'(d0_to), 1);
`else
    checkOutput("no_watchdog_bg", 0, 32'(d0_state), S_DRAW_BG);
    checkOutput("no_watchdog_flag", 0, 32'(d0_to), 0);
    applyStimulus(0, 0, 0, 1, 0, '0);
`endif

    // Random traffic on both sequencers with occasional mid-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 750 == 749) begin
        #2;
        resetn = 1'b0;
        @(negedge clk);
        #1;
        resetn = 1'b1;
      end
      applyRandom();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 SHALL have parameter NUM_STATUS, default 6, giving the number of status overlay channels (1..16).
REQ-002 SHALL have parameter SEQ_MODE, default 0, where 0 draws the highest-priority active overlay only and 1 draws every active overlay.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2^20, giving the plot watchdog limit; it is used only when the feature in REQ-024 is compiled in.
REQ-004 SHALL have these ports:
- clk  in  1  sole clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- go  in  1  advance from any WAIT state.
- go_start  in  1  leave the start screen.
- plot_done  in  1  single-cycle pulse from the plotter when the current draw completes.
- frame_tick  in  1  single-cycle frame strobe.
- status_en  in  NUM_STATUS  overlay requests; bit 0 has the highest priority.
- draw_scrn_start  out  1  start-screen plot enable.
- draw_scrn_game_bg  out  1  background plot enable.
- draw_ovl  out  NUM_STATUS  one-hot overlay plot enable.
- ovl_idx  out  clog2(NUM_STATUS)  index of the overlay currently selected.
- frame_overrun  out  1  single-cycle pulse when a frame_tick arrives mid-draw.
- plot_timeout  out  1  sticky watchdog flag.
- current_state  out  4  state code, for debug.

Function
REQ-005 SHALL implement the states IDLE, DRAW_START, WAIT_BG, DRAW_BG, SELECT, WAIT_OVL, DRAW_OVL and WAIT_TICK.
REQ-006 SHALL make these transitions:
- IDLE -> DRAW_START on go.
- DRAW_START -> WAIT_BG on go_start.
- WAIT_BG -> DRAW_BG on go.
- DRAW_BG -> SELECT on plot_done.
REQ-007 SHALL, on DRAW_BG plot_done, load pending <= status_en; in SEQ_MODE 0 the load is masked to the lowest set bit only.
REQ-008 SHALL, in SELECT, go to WAIT_OVL with ovl_idx = lowest set bit of pending when pending is nonzero, and go to WAIT_TICK otherwise; no state may hang when no request is active.
REQ-009 SHALL make these transitions:
- WAIT_OVL -> DRAW_OVL on go.
- DRAW_OVL -> SELECT on plot_done, clearing pending[ovl_idx] in the same edge.
REQ-010 SHALL make WAIT_TICK -> DRAW_BG on frame_tick or tick_pending, clearing tick_pending.
REQ-011 SHALL ignore status_en changes after the snapshot until the next DRAW_BG completes.
REQ-012 SHALL drive outputs as Moore outputs:
- draw_scrn_start = 1 only in DRAW_START.
- draw_scrn_game_bg = 1 only in DRAW_BG.
- draw_ovl[ovl_idx] = 1 only in DRAW_OVL; all other bits are 0.
REQ-013 SHALL, on frame_tick in any state other than IDLE, DRAW_START or WAIT_TICK, pulse frame_overrun for 1 cycle and set tick_pending; multiple ticks collapse into one.
REQ-014 SHALL treat a frame_tick coincident with the plot_done that enters WAIT_TICK as an overrun (tick_pending set), not lose it.
REQ-015 SHALL ignore plot_done outside the DRAW_* states.
REQ-016 SHALL allow a full frame of at most 2 + 3*NUM_STATUS state visits with no combinational loop from plot_done to draw_*.

Reset
REQ-017 SHALL, on resetn low, immediately force these values regardless of clk:
- state = IDLE.
- pending = 0, tick_pending = 0, ovl_idx = 0.
- frame_overrun = 0, plot_timeout = 0.
- all draw_* = 0.
- current_state = 0.
REQ-018 SHALL, on reset asserted mid-draw, drop draw enables in the same cycle and resume only via IDLE -> go.
REQ-019 SHALL release resetn synchronously; that is the integrator's responsibility and needs no internal synchronizer.

Configuration
REQ-020 SHALL, with DRAW_SEQ_TIMEOUT_EN defined, count cycles spent in any DRAW_* state.
REQ-021 SHALL, with DRAW_SEQ_TIMEOUT_EN defined, treat reaching TIMEOUT_CYCLES as a forced plot_done and set plot_timeout, which stays set until reset.
REQ-022 SHALL, with DRAW_SEQ_TIMEOUT_EN defined, reset the counter on every state change.
REQ-023 SHALL, with DRAW_SEQ_TIMEOUT_EN undefined, contain no counter and tie plot_timeout to 0.
REQ-024 SHALL make DRAW_SEQ_TIMEOUT_EN the only feature macro.

Structure
REQ-025 SHALL place the state encoding constants (IDLE=0 .. WAIT_TICK=7) and the 4-bit state typedef in the shared package draw_seq_pkg.
REQ-026 SHALL implement the lowest-set-bit search as sub-module prio_pick (NUM_STATUS-wide, producing index and valid), which is reused for SELECT and the mode-0 mask.

Verification
REQ-027 SHALL cover these directed scenarios:
- Mode 0, status_en=6'b010100 at bg done -> only draw_ovl=6'b000100 (ovl_idx=2), then WAIT_TICK.
- Mode 1, status_en=6'b100001 -> overlays 0 then 5 drawn, each after go/plot_done, then WAIT_TICK; status_en changing to 0 mid-sequence has no effect.
- status_en=0 at bg done -> SELECT -> WAIT_TICK in 2 cycles, no draw_ovl pulse.
- frame_tick during DRAW_OVL -> frame_overrun for 1 cycle; the later entry to WAIT_TICK exits to DRAW_BG the next cycle without a new tick.
- resetn low during DRAW_BG, asynchronously between edges -> draw_scrn_game_bg=0 before the next clk edge, state=IDLE.
- With DRAW_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16 and no plot_done in DRAW_BG -> SELECT after 16 cycles, plot_timeout=1 and stays set.
